// File: rtl/button_debouncer.sv
// Debouncer for a raw asynchronous input: synchronizer chain feeding a
// counter-qualified 4-state filter with registered level, edge pulses and busy flag.
//
//  state     | meaning
//  IDLE_LOW  | output low, synchronized input agrees
//  WAIT_HIGH | input high, counting toward a rising flip
//  IDLE_HIGH | output high, synchronized input agrees
//  WAIT_LOW  | input low, counting toward a falling flip
module button_debouncer #(
    parameter int unsigned SYNC_STAGES   = 2,
    parameter int unsigned STABLE_CYCLES = 16,
    parameter logic        INIT_LEVEL    = 1'b0
) (
    input  logic Clk_In,
    input  logic Reset_In,
    input  logic Button_In,
    output logic Level_Out,
    output logic Rise_Pulse_Out,
    output logic Fall_Pulse_Out,
    output logic Busy_Out
);

    if (SYNC_STAGES < 2 || STABLE_CYCLES < 2) begin : g_param_check
        $error("button_debouncer: SYNC_STAGES and STABLE_CYCLES must both be >= 2");
    end

    localparam int unsigned CW = (STABLE_CYCLES < 2) ? 1 : $clog2(STABLE_CYCLES);
    localparam logic [CW-1:0] CNT_LAST = CW'(STABLE_CYCLES - 1);

    localparam logic [1:0] IDLE_LOW  = 2'd0;
    localparam logic [1:0] WAIT_HIGH = 2'd1;
    localparam logic [1:0] IDLE_HIGH = 2'd2;
    localparam logic [1:0] WAIT_LOW  = 2'd3;
    localparam logic [1:0] RESET_STATE = INIT_LEVEL ? IDLE_HIGH : IDLE_LOW;

    logic [SYNC_STAGES-1:0] sync_q, sync_d;
    logic [1:0]             state_q, state_d;
    logic [CW-1:0]          cnt_q, cnt_d;
    logic                   level_q, level_d;
    logic                   rise_q, rise_d;
    logic                   fall_q, fall_d;
    logic                   busy_q, busy_d;
    logic                   s;

    assign sync_d = {sync_q[SYNC_STAGES-2:0], Button_In};
    assign s      = sync_q[SYNC_STAGES-1];

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        level_d = level_q;
        rise_d  = 1'b0;
        fall_d  = 1'b0;
        case (state_q)
            IDLE_LOW: begin
                if (s) begin
                    state_d = WAIT_HIGH;
                    cnt_d   = CW'(1);
                end else begin
                    cnt_d   = '0;
                end
            end
            WAIT_HIGH: begin
                if (!s) begin
                    state_d = IDLE_LOW;
                    cnt_d   = '0;
                end else if (cnt_q == CNT_LAST) begin
                    state_d = IDLE_HIGH;
                    level_d = 1'b1;
                    rise_d  = 1'b1;
                    cnt_d   = '0;
                end else begin
                    cnt_d   = cnt_q + CW'(1);
                end
            end
            IDLE_HIGH: begin
                if (!s) begin
                    state_d = WAIT_LOW;
                    cnt_d   = CW'(1);
                end else begin
                    cnt_d   = '0;
                end
            end
            WAIT_LOW: begin
                if (s) begin
                    state_d = IDLE_HIGH;
                    cnt_d   = '0;
                end else if (cnt_q == CNT_LAST) begin
                    state_d = IDLE_LOW;
                    level_d = 1'b0;
                    fall_d  = 1'b1;
                    cnt_d   = '0;
                end else begin
                    cnt_d   = cnt_q + CW'(1);
                end
            end
            default: begin
                state_d = RESET_STATE;
                cnt_d   = '0;
            end
        endcase
        // Busy tracks the state being entered so it lines up with the state register.
        busy_d = (state_d == WAIT_HIGH) || (state_d == WAIT_LOW);
    end

    always_ff @(posedge Clk_In or negedge Reset_In) begin
        if (!Reset_In) begin
            sync_q  <= {SYNC_STAGES{INIT_LEVEL}};
            state_q <= RESET_STATE;
            cnt_q   <= '0;
            level_q <= INIT_LEVEL;
            rise_q  <= 1'b0;
            fall_q  <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            sync_q  <= sync_d;
            state_q <= state_d;
            cnt_q   <= cnt_d;
            level_q <= level_d;
            rise_q  <= rise_d;
            fall_q  <= fall_d;
            busy_q  <= busy_d;
        end
    end

    assign Level_Out      = level_q;
    assign Rise_Pulse_Out = rise_q;
    assign Fall_Pulse_Out = fall_q;
    assign Busy_Out       = busy_q;

endmodule
